puf_response_collector: RTL and testbench
=========================================

# puf_response_collector

Sequencing and capture stage directly downstream of the ring-oscillator race arbiter. For each challenge it runs `RESP_W` consecutive races, clearing the race logic before each one, and shifts every `winner` bit into a response register. It then presents the assembled word with a ready/ack handshake to the consumer. It supplies the `response`/`ready` pair that the top-level PUF currently ties to zero.

## Interface

- `RESP_W`, 8: response width and number of races per challenge; range 1..16.
- `TIMEOUT`, 255: maximum RACE-state cycles allowed per bit before it is forced; range 2..65535.

- `clk` input 1: single system clock; all state changes on its rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `start` input 1: request a new evaluation; sampled only in IDLE.
- `winner` input 1: race arbiter winner bit; valid when `done`=1.
- `done` input 1: race arbiter finished flag (level).
- `ack` input 1: consumer has taken `response`; sampled only in HOLD.
- `race_clear` output 1: one-cycle pulse that clears the counter and arbiter before each race.
- `response` output RESP_W: assembled response; bit k is race k.
- `ready` output 1: `response` is valid and stable.
- `busy` output 1: evaluation in progress (CLEAR or RACE).
- `timeout_err` output 1: sticky flag; at least one bit of the current response was forced by timeout.

## Operation

- States: IDLE, CLEAR, RACE, HOLD. Registers:
  - `bit_idx`: width ceil(log2 RESP_W), minimum 1 bit.
  - `timer`: 16 bits.
  - `shreg`: RESP_W bits.
- IDLE:
  - `start`=1 → CLEAR.
  - On that transition, clear `bit_idx`, `shreg` and `timeout_err`.
- CLEAR:
  - `race_clear`=1 for exactly this one cycle.
  - `timer` ← 0; next state is RACE.
- RACE:
  - `timer` increments each cycle, saturating at 65535.
  - `done` is ignored while `timer`==0, to let `race_clear` propagate.
  - When `timer`≥1 and `done`=1: `shreg[bit_idx]` ← `winner`.
  - When `timer`==TIMEOUT and `done`=0: `shreg[bit_idx]` ← 0 and `timeout_err` ← 1.
  - If both conditions hold in the same cycle, `done` wins: capture `winner`, leave `timeout_err` unchanged.
  - After any capture: if `bit_idx`==RESP_W−1 → HOLD; otherwise `bit_idx`+1 → CLEAR.
- HOLD:
  - `ready`=1.
  - `ack`=1 → IDLE.
  - `start` is ignored; a `start` in the same cycle as `ack` is dropped and must be re-issued.
- `response` is driven from `shreg` continuously. It is stable throughout HOLD and keeps its last value through IDLE until the next accepted `start` clears it.
- `busy` = (state==CLEAR or RACE).
- `start` outside IDLE and `ack` outside HOLD have no effect.
- `winner` is ignored whenever `done`=0.

## Timing

- Reset (`rst`=0, asynchronous): state IDLE; `race_clear`=0, `response`=0, `ready`=0, `busy`=0, `timeout_err`=0; `bit_idx`=0, `timer`=0.
- Deassertion of `rst` is synchronised externally; the first active edge after release sees IDLE.
- Per bit, when `done` is already high: CLEAR (1 cycle) + RACE `timer`=0 (1 cycle) + RACE capture (1 cycle) = 3 cycles.
- `start` sampled at edge E0:
  - `race_clear` is high between E0 and E1.
  - The first bit is captured at E3.
  - Bit RESP_W−1 is captured at edge 3·RESP_W; for RESP_W=8, `ready` is high after E24.
- Bit forced by timeout: the capture happens on the edge that ends the cycle where `timer`==TIMEOUT, i.e. TIMEOUT+2 cycles after that bit's CLEAR.
- `ack` sampled at edge Ea in HOLD: `ready` is low after Ea, and `start` is accepted no earlier than edge Ea+1.
- Asserting `rst` mid-race aborts immediately: all outputs return to reset values, and the partial response is lost.

## Test plan

- Reset, then hold `done`=1, `winner`=1, pulse `start` → `ready` rises after the 24th edge, `response`=0xFF, `timeout_err`=0, exactly 8 `race_clear` pulses.
- `done`=1 with `winner` alternating 1,0,1,0,… per race → `response`=0x55; then `ack` → `ready` low next cycle and `response` still 0x55 in IDLE.
- `TIMEOUT`=4, `done` held 0 for race 3 only, `winner`=1 otherwise → `response`=0xF7 and `timeout_err`=1. Race 3 takes 6 cycles from its CLEAR; `ready` rises after edge 27.
- `done` already high during CLEAR and the first RACE cycle with `winner`=1, then `winner`=0 from the second RACE cycle on → the captured bit is 0, showing the first-cycle `done` is ignored.
- `start` pulsed in RACE and in HOLD, and `ack` pulsed in RACE → none has any effect; `start`+`ack` together in HOLD → IDLE with no new evaluation.
- `rst`=0 asserted at bit 4 in RACE → `busy`, `ready`, `response` and `timeout_err` are 0 immediately; the next `start` produces a full 8-bit evaluation.

Source files
------------

// File: rtl/puf_response_collector.sv
// Race sequencer and response capture for the ring-oscillator PUF arbiter.
// Runs RESP_W races per challenge and hands the word off with ready/ack.
module puf_response_collector #(
    parameter int unsigned RESP_W  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              winner,
    input  logic              done,
    input  logic              ack,
    output logic              race_clear,
    output logic [RESP_W-1:0] response,
    output logic              ready,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned IDX_W   = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam int unsigned TIMER_W = 16;

    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(RESP_W - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_V = TIMER_W'(TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RACE,
        S_HOLD
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   bit_idx;
    logic [TIMER_W-1:0] timer;
    logic [RESP_W-1:0]  shreg;

    // done is blanked while timer==0 so the clear pulse has reached the arbiter
    logic race_active_c;
    logic capture_c;
    assign race_active_c = (timer != '0);
    assign capture_c     = race_active_c && (done || (timer == TIMEOUT_V));

    assign response = shreg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            bit_idx     <= '0;
            timer       <= '0;
            shreg       <= '0;
            race_clear  <= 1'b0;
            ready       <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            race_clear <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_CLEAR;
                        bit_idx     <= '0;
                        shreg       <= '0;
                        timeout_err <= 1'b0;
                        race_clear  <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    timer <= '0;
                    state <= S_RACE;
                end
                S_RACE: begin
                    if (timer != TIMER_MAX) begin
                        timer <= timer + TIMER_W'(1);
                    end
                    if (capture_c) begin
                        // a real result always beats a coincident timeout
                        shreg[bit_idx] <= done ? winner : 1'b0;
                        if (!done) begin
                            timeout_err <= 1'b1;
                        end
                        if (bit_idx == LAST_IDX) begin
                            state <= S_HOLD;
                            busy  <= 1'b0;
                            ready <= 1'b1;
                        end else begin
                            bit_idx    <= bit_idx + IDX_W'(1);
                            state      <= S_CLEAR;
                            race_clear <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (ack) begin
                        state <= S_IDLE;
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_response_collector.sv
// Scoreboard bench for puf_response_collector with a reactive race-arbiter stand-in.
module tb_puf_response_collector;

    localparam int unsigned RESP_W  = 8;
    localparam int unsigned TIMEOUT = 4;

    logic              clk;
    logic              rst;
    logic              start;
    logic              winner;
    logic              done;
    logic              ack;
    logic              race_clear;
    logic [RESP_W-1:0] response;
    logic              ready;
    logic              busy;
    logic              timeout_err;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [7:0] resp;
        logic       err;
        int         lat;
    } exp_t;

    exp_t sb[$];

    puf_response_collector #(
        .RESP_W (RESP_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .winner     (winner),
        .done       (done),
        .ack        (ack),
        .race_clear (race_clear),
        .response   (response),
        .ready      (ready),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: fixed 3 cycles per race, a stalled race costs TIMEOUT+2 instead.
    function automatic exp_t model(input logic [7:0] pat, input int stall_bit, input int flip_bit);
        exp_t e;
        e.resp = pat;
        e.err  = 1'b0;
        e.lat  = 3 * RESP_W;
        if (flip_bit >= 0) e.resp[3'(flip_bit)] = 1'b0;
        if (stall_bit >= 0) begin
            e.resp[3'(stall_bit)] = 1'b0;
            e.err = 1'b1;
            e.lat = e.lat - 3 + int'(TIMEOUT) + 2;
        end
        return e;
    endfunction

    // Issues start, then plays the arbiter each cycle until ready (or abort).
    task automatic run_eval(input logic [7:0] pat, input int stall_bit, input int flip_bit,
                            input int inj_at, input int abort_bit,
                            output bit got_ready, output int elapsed, output int clears);
        int cur;
        int since;
        if (abort_bit < 0) sb.push_back(model(pat, stall_bit, flip_bit));
        got_ready = 1'b0;
        clears    = 0;
        cur       = -1;
        since     = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        elapsed = 0;
        while (elapsed <= 400) begin
            if (race_clear) begin
                cur   = clears;
                clears++;
                since = 0;
            end else begin
                since++;
            end
            if (cur >= 0 && cur < int'(RESP_W)) begin
                done   = (cur == stall_bit) ? 1'b0 : 1'b1;
                winner = (cur == flip_bit) ? (since < 2) : pat[3'(cur)];
            end
            if (inj_at >= 0) begin
                start = (elapsed == inj_at);
                ack   = (elapsed == inj_at);
            end
            if (abort_bit >= 0 && cur == abort_bit && since == 1) begin
                rst = 1'b0;
                break;
            end
            if (ready) begin
                got_ready = 1'b1;
                break;
            end
            @(negedge clk);
            elapsed++;
        end
        start = 1'b0;
        ack   = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        start  = 1'b0;
        ack    = 1'b0;
        done   = 1'b1;
        winner = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({race_clear, ready, busy, timeout_err} !== 4'b0000 || response !== 8'h00) begin
            n_errors++;
            $display("FAIL reset: rc/rdy/busy/err=%b resp=%h, required 0000 00",
                     {race_clear, ready, busy, timeout_err}, response);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release_idle: busy=%b ready=%b, required 0 0", busy, ready);
        end
    endtask

    task automatic check_result(input string name, input bit got, input int elapsed);
        exp_t e;
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL %s_ready_timeout: ready never rose, required within %0d edges", name, 3 * RESP_W);
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        if (response !== e.resp) begin
            n_errors++;
            $display("FAIL %s_response: got %h, required %h", name, response, e.resp);
        end
        n_checks++;
        if (timeout_err !== e.err) begin
            n_errors++;
            $display("FAIL %s_timeout_err: got %b, required %b", name, timeout_err, e.err);
        end
        n_checks++;
        if (elapsed !== e.lat) begin
            n_errors++;
            $display("FAIL %s_latency: ready after edge %0d, required %0d", name, elapsed, e.lat);
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_all_ones();
        bit got; int el; int cl;
        run_eval(8'hFF, -1, -1, -1, -1, got, el, cl);
        check_result("all_ones", got, el);
        n_checks++;
        if (cl !== 8) begin
            n_errors++;
            $display("FAIL all_ones_clear_pulses: got %0d, required 8", cl);
        end
        do_ack();
    endtask

    task automatic test_alternating();
        bit got; int el; int cl;
        run_eval(8'h55, -1, -1, -1, -1, got, el, cl);
        check_result("alternating", got, el);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        n_checks++;
        if (ready !== 1'b0 || response !== 8'h55 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL alt_after_ack: ready=%b busy=%b resp=%h, required 0 0 55", ready, busy, response);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (response !== 8'h55) begin
            n_errors++;
            $display("FAIL alt_idle_hold: resp=%h, required 55", response);
        end
    endtask

    task automatic test_timeout();
        bit got; int el; int cl;
        run_eval(8'hFF, 3, -1, -1, -1, got, el, cl);
        check_result("timeout", got, el);
        do_ack();
    endtask

    task automatic test_early_done();
        bit got; int el; int cl;
        run_eval(8'hFF, -1, 2, -1, -1, got, el, cl);
        check_result("early_done", got, el);
        do_ack();
    endtask

    task automatic test_ignored_controls();
        bit got; int el; int cl;
        run_eval(8'hA5, -1, -1, 4, -1, got, el, cl);
        check_result("race_start_ack", got, el);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || response !== 8'hA5) begin
            n_errors++;
            $display("FAIL hold_start: ready=%b busy=%b resp=%h, required 1 0 a5", ready, busy, response);
        end
        start = 1'b1;
        ack   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ack   = 1'b0;
        n_checks++;
        if (ready !== 1'b0) begin
            n_errors++;
            $display("FAIL start_ack_release: ready=%b, required 0", ready);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || race_clear !== 1'b0 || response !== 8'hA5) begin
            n_errors++;
            $display("FAIL start_ack_dropped: busy=%b race_clear=%b resp=%h, required 0 0 a5",
                     busy, race_clear, response);
        end
    endtask

    task automatic test_reset_mid_race();
        bit got; int el; int cl;
        run_eval(8'hFF, 1, -1, -1, 4, got, el, cl);
        #1;
        n_checks++;
        if ({busy, ready, timeout_err, race_clear} !== 4'b0000 || response !== 8'h00) begin
            n_errors++;
            $display("FAIL mid_race_reset: busy/rdy/err/rc=%b resp=%h, required 0000 00",
                     {busy, ready, timeout_err, race_clear}, response);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_eval(8'h3C, -1, -1, -1, -1, got, el, cl);
        check_result("after_reset", got, el);
        n_checks++;
        if (cl !== 8) begin
            n_errors++;
            $display("FAIL after_reset_clear_pulses: got %0d, required 8", cl);
        end
        do_ack();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_all_ones();
        test_alternating();
        test_timeout();
        test_early_done();
        test_ignored_controls();
        test_reset_mid_race();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
